updown_counter_ctrl: RTL and testbench
======================================

# updown_counter_ctrl

Controller that shares one 4-bit up/down counter between two requesters and sequences it through load-then-count-to-target jobs. Each requester supplies a start value and a target. The controller arbitrates round-robin, loads the start value, and steps the counter toward the target until it matches. It then pulses `done` for the granted requester. The block sits beside the counter and drives its `load`/`data`/`enable`/`select` pins, observing the counter value.

## Interface
- No parameters; all widths fixed at 4-bit counter value, 2 requesters.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  2  per-requester job request; level, held until `done` or withdrawn.
- `cfg0_start`, `cfg0_target`  in  4 each  requester 0 job; sampled only at grant.
- `cfg1_start`, `cfg1_target`  in  4 each  requester 1 job; sampled only at grant.
- `hold`  in  1  pause counting while high (RUN only).
- `cnt_out`  in  4  current counter value.
- `gnt`  out  2  one-hot grant; registered.
- `done`  out  2  one-cycle completion pulse for granted requester.
- `busy`  out  1  high whenever state is not IDLE.
- `cnt_load`  out  1  counter load strobe.
- `cnt_data`  out  4  counter load value (latched start).
- `cnt_enable`  out  1  counter count enable.
- `cnt_select`  out  1  counter direction; 1 = up, 0 = down.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - If any `req` bit is high, grant one, latch its start, target and `dir = (target >= start)`, then go to LOAD.
  - If only one bit is high, grant it.
  - If both are high, grant the index held in priority register `pri`.
- **LOAD**
  - `cnt_load`=1 for exactly one cycle; `cnt_data`=latched start.
  - Next state is RUN.
- **RUN**
  - `cnt_enable = !hold && (cnt_out != tgt)`; `cnt_select = dir`.
  - When `cnt_out == tgt`, go to DONE; `cnt_enable`=0 in that cycle.
  - Counting is monotonic toward the target, so no wrap-around can occur. 0→15 takes 15 up steps; 15→0 takes 15 down steps.
- **DONE**
  - `done[g]`=1 for one cycle; `gnt` is still asserted.
  - Next state is IDLE; `gnt` clears.
  - `pri` is set to the other index.
- **Abort**
  - If `req[g]` falls during LOAD or RUN, go to IDLE on the next edge and clear `gnt`.
  - No `done` pulse is issued; `pri` is set to the other index.
  - The counter keeps its current value.
- **Decoding**
  - `cnt_load` and `cnt_enable` are decoded from the state register and `cnt_out`; both are 0 outside LOAD and RUN.
  - `cnt_data` and `cnt_select` always show the latched registers.
- Config inputs changing after grant have no effect on the running job.
- **Reset values**
  - State IDLE; `gnt`=00, `done`=00, `busy`=0.
  - `cnt_load`=0, `cnt_enable`=0, `cnt_select`=0, `cnt_data`=0000.
  - `pri`=0, so requester 0 wins the first tie.

## Timing
- `req` is seen in IDLE at cycle T. The following outputs assert in cycle T+1:
  - `gnt`, `busy`, LOAD
  - `cnt_load`=1
- At the T+1→T+2 edge the counter takes the start value.
- RUN occupies cycles T+2 through T+2+|target−start|, with `hold` cycles adding to the count.
- `done` pulses in cycle T+3+|target−start|+(hold cycles). `gnt` drops one cycle later.
- start == target: `done` pulses at T+3.
- Back-to-back jobs: IDLE lasts one cycle minimum between jobs, so a new grant appears 2 cycles after `done`.
- `hold` asserted in the same cycle as the match: still go to DONE, since no step is needed.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronous). The job is lost and no `done` is issued.

## Test plan
- `req`=01 alone, cfg0 start=3, target=7 → `cnt_load` at T+1; `cnt_out` 3,4,5,6,7; `cnt_select`=1; `done[0]` at T+7; `gnt`=00 at T+8.
- `req`=10 alone, start=12, target=2, `hold` high for 3 cycles mid-RUN → `cnt_select`=0; 10 down steps; `cnt_enable`=0 during `hold`; `done[1]` at T+16.
- `req`=11 held continuously, both jobs 5→5 → grants alternate 0,1,0; each `done` comes 3 cycles after its grant cycle.
- Start=target=9 → `cnt_load` once, `cnt_enable` never high, `done` at T+3.
- `req[0]` dropped during RUN (0→15 job) → `gnt`=00 next cycle; no `done`; counter frozen; pending `req[1]` granted next.
- `rst_n` low during RUN → outputs reach reset values immediately; after release, `req`=11 grants requester 0.

Source files
------------

// File: rtl/updown_counter_ctrl.sv
// Round-robin job sequencer for a shared 4-bit up/down counter: loads a
// requester's start value, steps toward its target, then pulses done.
module updown_counter_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic [3:0] cfg0_start_i,
    input  logic [3:0] cfg0_target_i,
    input  logic [3:0] cfg1_start_i,
    input  logic [3:0] cfg1_target_i,
    input  logic       hold_i,
    input  logic [3:0] cnt_out_i,
    output logic [1:0] gnt_o,
    output logic [1:0] done_o,
    output logic       busy_o,
    output logic       cnt_load_o,
    output logic [3:0] cnt_data_o,
    output logic       cnt_enable_o,
    output logic       cnt_select_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t     state_q;
    logic [1:0] gnt_q;
    logic [1:0] done_q;
    logic       pri_q;
    logic [3:0] start_q;
    logic [3:0] tgt_q;
    logic       dir_q;

    logic       arb_idx_s;
    logic [3:0] arb_start_s;
    logic [3:0] arb_tgt_s;
    logic       gnt_req_s;

    // Arbitration: a lone requester wins outright, a tie goes to pri_q.
    always_comb begin
        arb_idx_s = pri_q;
        case (req_i)
            2'b01:   arb_idx_s = 1'b0;
            2'b10:   arb_idx_s = 1'b1;
            default: arb_idx_s = pri_q;
        endcase
        if (arb_idx_s) begin
            arb_start_s = cfg1_start_i;
            arb_tgt_s   = cfg1_target_i;
        end else begin
            arb_start_s = cfg0_start_i;
            arb_tgt_s   = cfg0_target_i;
        end
        gnt_req_s = |(req_i & gnt_q);
    end

    // Job sequencing FSM with registered grant/done; a withdrawn request aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            pri_q   <= 1'b0;
            start_q <= 4'd0;
            tgt_q   <= 4'd0;
            dir_q   <= 1'b0;
        end else begin
            done_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        gnt_q   <= arb_idx_s ? 2'b10 : 2'b01;
                        start_q <= arb_start_s;
                        tgt_q   <= arb_tgt_s;
                        dir_q   <= (arb_tgt_s >= arb_start_s);
                        state_q <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (!gnt_req_s) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= 2'b00;
                        pri_q   <= ~gnt_q[1];
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!gnt_req_s) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= 2'b00;
                        pri_q   <= ~gnt_q[1];
                    end else if (cnt_out_i == tgt_q) begin
                        state_q <= ST_DONE;
                        done_q  <= gnt_q;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 2'b00;
                    pri_q   <= ~gnt_q[1];
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign cnt_load_o   = (state_q == ST_LOAD);
    assign cnt_enable_o = (state_q == ST_RUN) && !hold_i && (cnt_out_i != tgt_q);
    assign cnt_data_o   = start_q;
    assign cnt_select_o = dir_q;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Directed bench for updown_counter_ctrl with a behavioural counter and a
// scoreboard of expected done pulses (requester, cycle).
module tb_updown_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [3:0] c0s = 4'd0, c0t = 4'd0, c1s = 4'd0, c1t = 4'd0;
    logic       hold = 1'b0;
    logic [3:0] cnt = 4'd0;
    logic [1:0] gnt_o, done_o;
    logic       busy_o, cnt_load_o, cnt_enable_o, cnt_select_o;
    logic [3:0] cnt_data_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sb[$];

    updown_counter_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_i(req),
        .cfg0_start_i(c0s), .cfg0_target_i(c0t),
        .cfg1_start_i(c1s), .cfg1_target_i(c1t),
        .hold_i(hold), .cnt_out_i(cnt),
        .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o),
        .cnt_load_o(cnt_load_o), .cnt_data_o(cnt_data_o),
        .cnt_enable_o(cnt_enable_o), .cnt_select_o(cnt_select_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External counter driven by the controller's pins.
    always @(posedge clk) begin
        if (cnt_load_o) cnt <= cnt_data_o;
        else if (cnt_enable_o) cnt <= cnt_select_o ? cnt + 4'd1 : cnt - 4'd1;
    end

    // Scoreboard: every done pulse must match the next expected (requester, cycle).
    always @(negedge clk) begin
        int e;
        if (rst_n && done_o != 2'b00) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $error("FAIL sb_unexpected observed=%b@%0d expected=none", done_o, cyc);
            end else begin
                e = sb.pop_front();
                assert ({done_o, cyc[15:0]} === {((e / 65536) == 1) ? 2'b10 : 2'b01, e[15:0]})
                else begin
                    bad++;
                    $error("FAIL sb_done observed=%b@%0d expected=req%0d@%0d",
                           done_o, cyc, e / 65536, e % 65536);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_done(input int idx, input int at);
        sb.push_back(idx * 65536 + at);
    endtask

    task automatic wait_done(input string tag, input logic [1:0] exp);
        int n = 0;
        while (done_o == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, done_o, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"}, gnt_o, 2'b00);
        chk({tag, "_done"}, done_o, 2'b00);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_load"}, cnt_load_o, 1'b0);
        chk({tag, "_en"}, cnt_enable_o, 1'b0);
        chk({tag, "_sel"}, cnt_select_o, 1'b0);
        chk({tag, "_data"}, cnt_data_o, 4'd0);
    endtask

    initial begin
        int t;
        int nload;
        int nen;

        tick(2);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Job 3 -> 7 on requester 0; config changes after grant are ignored.
        t = cyc;
        req = 2'b01; c0s = 4'd3; c0t = 4'd7;
        expect_done(0, t + 7);
        chk("t1_idle_busy", busy_o, 1'b0);
        tick();
        chk("t1_gnt", gnt_o, 2'b01);
        chk("t1_busy", busy_o, 1'b1);
        chk("t1_load", cnt_load_o, 1'b1);
        chk("t1_data", cnt_data_o, 4'd3);
        c0s = 4'd14; c0t = 4'd1;
        tick();
        chk("t1_cnt_start", cnt, 4'd3);
        chk("t1_sel", cnt_select_o, 1'b1);
        chk("t1_en", cnt_enable_o, 1'b1);
        chk("t1_load_off", cnt_load_o, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t1_cnt", cnt, 3 + k);
        end
        chk("t1_en_match", cnt_enable_o, 1'b0);
        tick();
        chk("t1_done", done_o, 2'b01);
        chk("t1_done_gnt", gnt_o, 2'b01);
        req = 2'b00;
        tick();
        chk("t1_gnt_clr", gnt_o, 2'b00);
        chk("t1_busy_clr", busy_o, 1'b0);

        // Job 12 -> 2 on requester 1 with three hold cycles.
        t = cyc;
        req = 2'b10; c1s = 4'd12; c1t = 4'd2;
        expect_done(1, t + 16);
        tick(2);
        chk("t2_sel", cnt_select_o, 1'b0);
        chk("t2_cnt_start", cnt, 4'd12);
        tick(2);
        hold = 1'b1;
        #1;
        chk("t2_hold_en", cnt_enable_o, 1'b0);
        tick(3);
        chk("t2_hold_cnt", cnt, 4'd10);
        hold = 1'b0;
        wait_done("t2_done", 2'b10);
        req = 2'b00;
        tick();

        // Both requesting 5 -> 5: grants alternate 0, 1, 0.
        t = cyc;
        req = 2'b11; c0s = 4'd5; c0t = 4'd5; c1s = 4'd5; c1t = 4'd5;
        expect_done(0, t + 3);
        expect_done(1, t + 7);
        expect_done(0, t + 11);
        tick();
        chk("t3_gnt_a", gnt_o, 2'b01);
        tick(4);
        chk("t3_gnt_b", gnt_o, 2'b10);
        tick(4);
        chk("t3_gnt_c", gnt_o, 2'b01);
        tick(2);
        chk("t3_done_c", done_o, 2'b01);
        req = 2'b00;
        tick();

        // start == target: one load, no enable, done at T+3.
        t = cyc;
        req = 2'b01; c0s = 4'd9; c0t = 4'd9;
        expect_done(0, t + 3);
        nload = 0;
        nen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (cnt_load_o) nload++;
            if (cnt_enable_o) nen++;
        end
        chk("t4_done", done_o, 2'b01);
        chk("t4_nload", nload, 1);
        chk("t4_nen", nen, 0);
        req = 2'b00;
        tick();

        // Abort requester 0 mid-RUN; pending requester 1 is served next.
        t = cyc;
        req = 2'b01; c0s = 4'd0; c0t = 4'd15; c1s = 4'd8; c1t = 4'd10;
        tick();
        req = 2'b11;
        chk("t5_gnt", gnt_o, 2'b01);
        tick(4);
        chk("t5_cnt_pre", cnt, 4'd3);
        req = 2'b10;
        tick();
        chk("t5_abort_gnt", gnt_o, 2'b00);
        chk("t5_abort_busy", busy_o, 1'b0);
        chk("t5_abort_done", done_o, 2'b00);
        chk("t5_abort_cnt", cnt, 4'd4);
        expect_done(1, t + 11);
        tick();
        chk("t5_next_gnt", gnt_o, 2'b10);
        chk("t5_frozen_cnt", cnt, 4'd4);
        chk("t5_next_data", cnt_data_o, 4'd8);
        wait_done("t5_done", 2'b10);
        req = 2'b00;
        tick();

        // Asynchronous reset mid-RUN, then a tie goes to requester 0.
        req = 2'b01; c0s = 4'd0; c0t = 4'd15;
        tick(4);
        chk("t6_busy_pre", busy_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6_rst");
        tick();
        rst_n = 1'b1;
        c0s = 4'd2; c0t = 4'd3; c1s = 4'd1; c1t = 4'd1;
        req = 2'b11;
        t = cyc;
        expect_done(0, t + 4);
        tick();
        chk("t6_gnt", gnt_o, 2'b01);
        req = 2'b01;
        wait_done("t6_done", 2'b01);
        req = 2'b00;
        tick(3);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
